// File: rtl/toggle_decoder_pkg.sv
// rtl/toggle_decoder_pkg.sv - shared types and constants for the level-to-toggle decoder
//
// Contents:
//   state_t          decoder FSM states (ST_INIT, ST_ARMED)
//   SYNC_STAGES_MIN  smallest synchronizer depth that gives metastability settling time
package toggle_decoder_pkg;

  // INIT waits for the synchronizer to flush its reset zeros before a
  // baseline is taken; ARMED compares every cycle until the next reset.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_ARMED = 1'b1
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;

endpackage : toggle_decoder_pkg

// File: rtl/sync_chain.sv
// rtl/sync_chain.sv - parameterized multi-flop synchronizer with async active-low reset
//
// Ports:
//   clk    in   destination clock
//   reset  in   asynchronous active-low reset, clears every stage to 0
//   d      in   signal from a foreign (or unknown) clock domain
//   q      out  synchronized signal, STAGES clk edges behind d
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] stages;

  // Stage 0 may go metastable; later stages give it time to resolve.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stages <= '0;
    end else begin
      stages <= {stages[STAGES-2:0], d};
    end
  end

  assign q = stages[STAGES-1];

endmodule : sync_chain

// File: rtl/toggle_decoder.sv
// rtl/toggle_decoder.sv - recovers toggle events from a toggle-encoded level and counts them
//
// Parameters:
//   SYNC_STAGES  synchronizer depth on q_in (>= 2)
//   CNT_W        width of the pending-toggle counter
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-low reset
//   q_in       in   toggle-encoded level, may be asynchronous to clk
//   en         in   decode enable; toggles seen while low are discarded
//   clr        in   clears the sticky overflow flag
//   evt_ready  in   consumer accepts evt_count this cycle
//   t_out      out  one-cycle pulse per detected toggle
//   level      out  synchronized copy of q_in
//   evt_valid  out  evt_count is non-zero
//   evt_count  out  number of pending toggles (saturating)
//   overflow   out  sticky: a toggle was lost to saturation
module toggle_decoder
  import toggle_decoder_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             q_in,
  input  logic             en,
  input  logic             clr,
  input  logic             evt_ready,
  output logic             t_out,
  output logic             level,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow
);

  localparam int               INIT_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync_stages
      $error("toggle_decoder: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
    end
  endgenerate

  logic             sync_last;
  logic             baseline;
  state_t           state;
  logic [INIT_W-1:0] init_cnt;

  logic             toggle_seen;
  logic             hit;
  logic             xfer;
  logic             at_max;
  logic             ovf_set;
  logic [CNT_W-1:0] count_next;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (q_in),
    .q     (sync_last)
  );

  // The last synchronizer stage is already a flop, so level is registered.
  assign level = sync_last;

  // Baseline holds last cycle's synchronized level; any difference is one toggle.
  assign toggle_seen = (state == ST_ARMED) && (sync_last != baseline);
  assign hit         = toggle_seen && en;
  assign xfer        = evt_valid && evt_ready;
  assign at_max      = (evt_count == CNT_MAX);

  // A hand-off beats saturation: the toggle arriving with it starts the new
  // batch, so nothing is lost and overflow stays clear.
  assign ovf_set = hit && !xfer && at_max;

  always_comb begin
    count_next = evt_count;
    if (xfer) begin
      count_next = CNT_W'(hit);
    end else if (hit && !at_max) begin
      count_next = evt_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      baseline  <= 1'b0;
      t_out     <= 1'b0;
      evt_valid <= 1'b0;
      evt_count <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        // Wait until the reset zeros have left the synchronizer, then take
        // the first real sample as baseline so a level held high through
        // reset does not read as a toggle.
        ST_INIT: begin
          t_out <= 1'b0;
          if (init_cnt == INIT_W'(SYNC_STAGES)) begin
            baseline <= sync_last;
            state    <= ST_ARMED;
          end else begin
            init_cnt <= init_cnt + INIT_W'(1);
          end
        end
        // Baseline tracks regardless of en so re-enabling never replays
        // an edge that happened while disabled.
        ST_ARMED: begin
          baseline <= sync_last;
          t_out    <= hit;
        end
        default: begin
          state <= ST_INIT;
          t_out <= 1'b0;
        end
      endcase

      evt_count <= count_next;
      evt_valid <= (count_next != '0);

      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule : toggle_decoder

// File: tb/tb_toggle_decoder.sv
// tb/tb_toggle_decoder.sv - scoreboard bench for toggle_decoder with a behavioural toggle model
module tb_toggle_decoder;

  localparam int S    = 2;
  localparam int W    = 4;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         q_in;
  logic         en;
  logic         clr;
  logic         evt_ready;
  logic         t_out;
  logic         level;
  logic         evt_valid;
  logic [W-1:0] evt_count;
  logic         overflow;

  always #5 clk = ~clk;

  toggle_decoder #(
    .SYNC_STAGES (S),
    .CNT_W       (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .q_in      (q_in),
    .en        (en),
    .clr       (clr),
    .evt_ready (evt_ready),
    .t_out     (t_out),
    .level     (level),
    .evt_valid (evt_valid),
    .evt_count (evt_count),
    .overflow  (overflow)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Expected evt_count after each t_out pulse, and expected count handed off
  // on each transfer.
  int t_q[$];
  int x_q[$];

  // Reference model: q_in as sampled at each edge since reset release.
  bit qh[0:8191];
  int e;
  int m_cnt;
  bit m_ovf;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // A q_in sample reaches the comparison S edges later; it is a toggle when it
  // differs from the sample one edge older. The first S+1 edges after reset
  // release only fill the synchronizer and take the baseline.
  task automatic model_edge(input bit ev, input bit rv, input bit cv);
    bit det, hit, xfer, sat;
    det  = (e >= S + 2) && (qh[e-S] != qh[e-S-1]);
    hit  = det && ev;
    xfer = (m_cnt != 0) && rv;
    sat  = hit && !xfer && (m_cnt == MAXC);
    if (xfer)                     m_cnt = hit ? 1 : 0;
    else if (hit && m_cnt < MAXC) m_cnt = m_cnt + 1;
    if (sat)     m_ovf = 1'b1;
    else if (cv) m_ovf = 1'b0;
    if (hit) t_q.push_back(m_cnt);
  endtask

  task automatic step(input bit qv, input bit ev, input bit rv, input bit cv);
    q_in      = qv;
    en        = ev;
    evt_ready = rv;
    clr       = cv;
    if (m_cnt != 0 && rv) x_q.push_back(m_cnt);
    @(posedge clk);
    #1;
    e++;
    qh[e] = qv;
    model_edge(ev, rv, cv);
  endtask

  task automatic idle(input int n, input bit ev = 1'b1);
    repeat (n) step(q_in, ev, 1'b0, 1'b0);
  endtask

  task automatic toggle_n(input int n, input int gap, input bit ev = 1'b1);
    for (int i = 0; i < n; i++) begin
      step(~q_in, ev, 1'b0, 1'b0);
      repeat (gap - 1) step(q_in, ev, 1'b0, 1'b0);
    end
  endtask

  task automatic model_reset();
    e     = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_t_out"},     t_out,     0);
    chk({tag, "_level"},     level,     0);
    chk({tag, "_evt_valid"}, evt_valid, 0);
    chk({tag, "_evt_count"}, evt_count, 0);
    chk({tag, "_overflow"},  overflow,  0);
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT pulses t_out or
  // presents a transfer.
  always @(negedge clk) begin
    if (reset) begin
      if (t_out) begin
        if (t_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL t_out_unexpected: got 1 expected 0 (t=%0t)", $time);
        end else begin
          chk("t_out_count", evt_count, t_q.pop_front());
          chk("t_out_valid", evt_valid, 1);
        end
      end
      if (evt_valid && evt_ready) begin
        if (x_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL xfer_unexpected: got count %0d expected no transfer (t=%0t)", evt_count, $time);
        end else begin
          chk("xfer_count", evt_count, x_q.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    bit qv, ev;
    int hold;

    reset = 1'b0; q_in = 1'b1; en = 1'b1; clr = 1'b0; evt_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b1;

    // q_in held high through reset must not produce a toggle.
    idle(10);
    chk("t1_level", level, 1);
    chk("t1_evt_valid", evt_valid, 0);

    // Latency: change before edge n, t_out after edge n+2 only.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t2_t_out_n", t_out, 0);
    chk("t2_level_n", level, 1);
    idle(1);
    chk("t2_t_out_n1", t_out, 0);
    chk("t2_level_n1", level, 0);
    idle(1);
    chk("t2_t_out_n2", t_out, 1);
    chk("t2_count", evt_count, 1);
    chk("t2_valid", evt_valid, 1);
    idle(1);
    chk("t2_t_out_n3", t_out, 0);

    // Five toggles accumulated, then one transfer drains them.
    step(q_in, 1'b1, 1'b1, 1'b0);
    idle(2);
    toggle_n(5, 3);
    idle(3);
    chk("t3_count", evt_count, 5);
    chk("t3_valid", evt_valid, 1);
    step(q_in, 1'b1, 1'b1, 1'b0);
    chk("t3_count_after", evt_count, 0);
    chk("t3_valid_after", evt_valid, 0);

    // Saturation and sticky overflow.
    toggle_n(17, 2);
    idle(3);
    chk("t4_count", evt_count, MAXC);
    chk("t4_overflow", overflow, 1);
    step(q_in, 1'b1, 1'b0, 1'b1);
    chk("t4_overflow_clr", overflow, 0);
    chk("t4_count_kept", evt_count, MAXC);

    // Transfer coinciding with a detected toggle.
    step(q_in, 1'b1, 1'b1, 1'b0);
    idle(2);
    toggle_n(3, 3);
    idle(3);
    chk("t5_count3", evt_count, 3);
    step(~q_in, 1'b1, 1'b0, 1'b0);
    idle(1);
    step(q_in, 1'b1, 1'b1, 1'b0);
    chk("t5_t_out", t_out, 1);
    chk("t5_count", evt_count, 1);
    chk("t5_valid", evt_valid, 1);
    idle(1);
    toggle_n(3, 3, 1'b0);
    idle(3, 1'b0);
    chk("t5_count_disabled", evt_count, 1);
    idle(5);
    chk("t5_count_reenabled", evt_count, 1);

    // Asynchronous reset mid-burst with seven pending.
    step(q_in, 1'b1, 1'b1, 1'b0);
    idle(2);
    if (q_in == 1'b1) begin
      toggle_n(1, 3);
      step(q_in, 1'b1, 1'b1, 1'b0);
      idle(2);
    end
    toggle_n(7, 2);
    idle(3);
    chk("t6_count", evt_count, 7);
    chk("t6_level", level, 1);
    chk("t6_t_q_empty", t_q.size(), 0);
    chk("t6_x_q_empty", x_q.size(), 0);
    step(~q_in, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk_all_zero("t6_async");
    q_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t6_init_t_out", t_out, 0);
    end
    chk("t6_level_after", level, 1);

    // Randomized traffic against the reference model.
    qv = q_in; ev = 1'b1; hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        qv   = ~qv;
        hold = $urandom_range(2, 5);
      end
      hold--;
      if ($urandom_range(0, 19) == 0) ev = ~ev;
      step(qv, ev, $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 5);
    end
    for (int i = 0; i < 400; i++) begin
      if (hold == 0) begin
        qv   = ~qv;
        hold = $urandom_range(1, 3);
      end
      hold--;
      step(qv, 1'b1, $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3);
    end
    idle(4);
    chk("rand_count", evt_count, m_cnt);
    chk("rand_valid", evt_valid, (m_cnt != 0) ? 1 : 0);
    chk("rand_overflow", overflow, m_ovf);
    step(q_in, 1'b1, 1'b1, 1'b0);
    chk("rand_count_drained", evt_count, 0);
    idle(2);
    chk("end_t_q_empty", t_q.size(), 0);
    chk("end_x_q_empty", x_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_toggle_decoder

// File: doc/toggle_decoder.md
# toggle_decoder

Level-to-toggle decoder: the inverse of the team's T flip-flop. It watches a level signal produced by a toggle source, such as a T flip-flop output or a toggle-encoded flag from another clock domain, and recovers the toggle events from it. It synchronizes the input, emits a one-cycle `t_out` pulse per level change, and accumulates pending toggles behind a valid/ready handshake. It sits on the receive side of any toggle-encoded event link.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth. Minimum 2; values below 2 are a elaboration error.
- `CNT_W`, default 8: width of the pending-toggle counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `q_in`  in  1  toggle-encoded level; may be asynchronous to `clk`.
- `en`  in  1  decode enable; toggles seen while low are discarded.
- `clr`  in  1  clears the sticky `overflow`.
- `evt_ready`  in  1  consumer accepts `evt_count`.
- `t_out`  out  1  one-cycle pulse per detected toggle.
- `level`  out  1  synchronized copy of `q_in`.
- `evt_valid`  out  1  high when `evt_count` is non-zero.
- `evt_count`  out  CNT_W  number of pending toggles.
- `overflow`  out  1  sticky flag: a toggle was lost to saturation.

## Operation
- Reset (`reset`=0) is asynchronous. Immediately on assertion:
  - sync chain, baseline register and `level` = 0;
  - `t_out`, `evt_valid`, `evt_count`, `overflow` = 0;
  - state = INIT.
- FSM states:
  - INIT: counts SYNC_STAGES cycles after reset release. Then it loads the baseline from the last sync stage and moves to ARMED. No `t_out` is produced in INIT, so a `q_in` held at 1 through reset creates no spurious toggle.
  - ARMED: toggle detected when sync_last != baseline. The baseline updates every cycle, regardless of `en`.
  - ARMED is left only by reset.
- When a toggle is detected with `en`=1:
  - `t_out` = 1 for exactly one cycle;
  - the counter increments.
- With `en`=0 the toggle is dropped. Because the baseline still tracks, re-enabling never replays stale edges.
- Handshake: a transfer occurs when `evt_valid` && `evt_ready`. On that edge the counter loads 0, or 1 if a toggle is detected in the same cycle. `evt_count` is stable while `evt_valid`=1 and `evt_ready`=0, except that it increments on new toggles.
- Saturation: when the counter is at 2^CNT_W−1 and a new toggle arrives without a transfer, the counter holds and `overflow` sets. A transfer in the same cycle takes priority (counter loads 1, no overflow).
- `overflow` clears on `clr`=1. If `clr` and a new overflow occur in the same cycle, set wins.
- Counter arithmetic is unsigned CNT_W bits and never wraps.

## Timing
- A `q_in` change that meets setup before rising edge n causes:
  - `level` to change after edge n+SYNC_STAGES−1;
  - `t_out` high in the cycle after edge n+SYNC_STAGES (latency SYNC_STAGES+1 edges);
  - `evt_count`/`evt_valid` to update on the same edge as `t_out`.
- All outputs are registered; there are no combinational input-to-output paths.
- Each `q_in` level must be held ≥2 clk cycles to guarantee detection. Shorter pulses may be lost; they are not an error.
- `evt_ready` may be asserted at any time. A transfer with `evt_valid`=0 is a no-op.
- Reset asserted mid-operation discards all pending counts. INIT restarts on release.

## Structure
- Package `toggle_decoder_pkg`:
  - state enum (INIT, ARMED);
  - `SYNC_STAGES_MIN` = 2.
- Sub-module `sync_chain`: a parameterized SYNC_STAGES flop synchronizer with async active-low reset to 0. Reusable across the codebase.
- The top level holds the FSM, baseline register, edge detect, counter and handshake.

## Test plan
All scenarios use SYNC_STAGES=2, CNT_W=4.
1. Hold `q_in`=1 through reset, release, run 10 cycles → `t_out` never 1, `level`=1, `evt_valid`=0.
2. `q_in` 0→1 before edge n, `evt_ready`=0 → `t_out`=1 only in the cycle after edge n+2; `evt_count`=1, `evt_valid`=1.
3. 5 toggles spaced 3 cycles with `evt_ready`=0, then `evt_ready`=1 for one cycle → transfer sees `evt_count`=5; next cycle `evt_count`=0, `evt_valid`=0.
4. 17 toggles with `evt_ready`=0 → `evt_count` stops at 15, `overflow`=1; then `clr` pulse → `overflow`=0, `evt_count` still 15.
5. Transfer in the same cycle a toggle is detected, `evt_count`=3 → next `evt_count`=1, `evt_valid` stays 1. Toggles with `en`=0 → no `t_out`, count unchanged; re-enable → no pulse.
6. Assert `reset` mid-burst with `evt_count`=7 → all outputs 0 immediately without a clock edge; after release, no `t_out` for the INIT period.
